sid_bus_master: RTL and testbench
=================================

Name: sid_bus_master

Overview:
Bus initiator that drives the SID register interface (WR/ADDR/DATAW, samples DATAR) from a queued command stream: register writes, register reads and timed delays.
It sits between a host-side command source (UART/SPI/playback ROM) and the sid core, replacing the C64 CPU side of the bus.
All bus operations are paced to the 1 MHz CLKen strobe. Delays are counted in CLKen ticks, so register dumps play back at the original timing.

Parameters:
FIFO_DEPTH, 16, number of queued commands (power of two, >=2)
LVL_W, $clog2(FIFO_DEPTH+1), width of the LEVEL output

Ports:
CLK  in  1  master clock (same as sid core)
RSTn  in  1  reset; asynchronous, active-low
CLKen  in  1  1 MHz enable strobe, one CLK cycle wide
CMD_VALID  in  1  command offered
CMD_READY  out  1  command accepted when VALID&READY
CMD_OP  in  2  0=write, 1=read, 2=delay, 3=reserved (ignored, consumed as no-op)
CMD_ADDR  in  5  SID register address
CMD_DATA  in  16  write: [7:0] data; delay: tick count N
RSP_VALID  out  1  read response available
RSP_READY  in  1  response consumed when VALID&READY
RSP_ADDR  out  5  address of the read
RSP_DATA  out  8  DATAR value sampled
WR  out  1  SID write strobe
ADDR  out  5  SID address
DATAW  out  8  SID write data
DATAR  in  8  SID read data (combinational in sid)
FLUSH  in  1  synchronous abort and clear
BUSY  out  1  state != IDLE or FIFO not empty
LEVEL  out  LVL_W  FIFO occupancy

Behaviour:
- Reset (RSTn low, async): FIFO empty, state IDLE, delay counter 0. WR=0, ADDR=0, DATAW=0, RSP_VALID=0, RSP_ADDR=0, RSP_DATA=0, LEVEL=0, BUSY=0.
- FIFO: CMD_READY = !full & !FLUSH. Push on VALID&READY. Push and pop in the same cycle leave LEVEL unchanged. When full, no push occurs; the pop frees a slot and READY rises the next cycle.
- FSM states: IDLE, ISSUE, DELAY, RESP.
- IDLE: if FIFO non-empty, pop the head on this edge.
  - Write or read: register ADDR<=CMD_ADDR and, for writes, DATAW<=CMD_DATA[7:0]; go to ISSUE.
  - Delay with N>0: load counter=N; go to DELAY. Delay with N=0, or reserved op: stay in IDLE; the next pop can occur on the following cycle.
- ISSUE: wait for a cycle with CLKen=1. On that edge:
  - Write: WR<=1 for exactly one CLK cycle (the cycle after the CLKen cycle); go to IDLE.
  - Read: RSP_DATA<=DATAR, RSP_ADDR<=ADDR, RSP_VALID<=1; go to RESP.
- At most one bus operation per CLKen tick. ADDR/DATAW hold their values after the operation until the next pop.
- DELAY: decrement the counter on each CLKen cycle; go to IDLE on the edge where the counter goes 1->0. Total wait is exactly N CLKen ticks, measured from entry.
- RESP: hold RSP_* stable until RSP_READY. On VALID&READY, RSP_VALID<=0 and go to IDLE. The FIFO is not popped while in RESP.
- FLUSH (sampled high on an edge): FIFO cleared, state<=IDLE, counter<=0, WR<=0, RSP_VALID<=0. FLUSH wins over a simultaneous push, pop or CLKen. ADDR/DATAW are retained.
- Reset asserted mid-operation aborts immediately with no further WR pulse. After release, the first pop can occur on the first edge with RSTn high.
- Counter is 16 bits; N=65535 is valid. There is no wrap, because the counter is only loaded from N.

Test Plan:
- Reset then push write(0x18,0x0F), write(0x00,0x34) -> two WR pulses, each one CLK wide, on consecutive CLKen ticks; ADDR/DATAW=0x18/0x0F, then 0x00/0x34; LEVEL returns to 0, BUSY falls.
- Push write(0x04,0x11), delay(3), write(0x04,0x10) -> exactly 4 CLKen ticks between the two WR pulses (1 issue + 3 delay); delay(0) inserted in the sequence adds no tick.
- DATAR model returns 0xA5 for addr 0x1B; push read(0x1B) with RSP_READY=0 for 10 cycles -> RSP_VALID=1, RSP_ADDR=0x1B, RSP_DATA=0xA5 held stable; a queued write is not issued until RSP_READY=1.
- Push 17 commands back-to-back with FIFO_DEPTH=16 while in a long delay -> CMD_READY low after 16, LEVEL=16; after the delay expires and one pop occurs, READY rises and the 17th is accepted.
- FLUSH mid delay(1000) with 5 queued -> next cycle LEVEL=0, BUSY=0, no WR pulse ever; a subsequent write issues on the next CLKen tick.
- Assert RSTn low during ISSUE of a write -> WR stays 0, all outputs at reset values asynchronously.

Source files
------------

// File: rtl/sid_bus_master.sv
// sid_bus_master
// Bus initiator for the SID register interface. Commands (write, read, delay)
// are queued in a FIFO and executed one at a time, with every bus operation and
// every delay tick paced to the 1 MHz CLKen strobe.
//
// Ports:
//   CLK, RSTn            master clock, asynchronous active-low reset
//   CLKen                1 MHz enable strobe, one CLK cycle wide
//   CMD_VALID/READY      command handshake; CMD_OP 0=write 1=read 2=delay 3=no-op
//   CMD_ADDR, CMD_DATA   register address; write data [7:0] or delay tick count
//   RSP_VALID/READY      read response handshake; RSP_ADDR/RSP_DATA hold the result
//   WR, ADDR, DATAW      SID bus outputs; DATAR is the SID read data
//   FLUSH                synchronous abort: clears the queue and any pending work
//   BUSY, LEVEL          activity flag and FIFO occupancy
module sid_bus_master #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             CLKen,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [4:0]       CMD_ADDR,
    input  logic [15:0]      CMD_DATA,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [4:0]       RSP_ADDR,
    output logic [7:0]       RSP_DATA,
    output logic             WR,
    output logic [4:0]       ADDR,
    output logic [7:0]       DATAW,
    input  logic [7:0]       DATAR,
    input  logic             FLUSH,
    output logic             BUSY,
    output logic [LVL_W-1:0] LEVEL
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] OpWrite = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpDelay = 2'd2;

    typedef enum logic [1:0] {StIdle, StIssue, StDelay, StResp} state_e;

    // FIFO entry layout: {op[1:0], addr[4:0], data[15:0]}
    logic [22:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        is_read_q, is_read_d;
    logic [4:0]  addr_q, addr_d;
    logic [7:0]  dataw_q, dataw_d;
    logic        wr_q, wr_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [4:0]  rsp_addr_q, rsp_addr_d;
    logic [7:0]  rsp_data_q, rsp_data_d;

    logic        full, empty, cmd_ready, push, pop;
    logic [22:0] head;
    logic [1:0]  head_op;
    logic [4:0]  head_addr;
    logic [15:0] head_data;

    assign full      = (count_q == LVL_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full && !FLUSH;
    assign push      = CMD_VALID && cmd_ready;
    assign head      = mem_q[rd_ptr_q];
    assign head_op   = head[22:21];
    assign head_addr = head[20:16];
    assign head_data = head[15:0];

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {CMD_OP, CMD_ADDR, CMD_DATA};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        dataw_d     = dataw_q;
        wr_d        = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        pop         = 1'b0;

        if (FLUSH) begin
            // ADDR/DATAW deliberately keep their last values.
            state_d     = StIdle;
            cnt_d       = '0;
            rsp_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!empty) begin
                        pop = 1'b1;
                        case (head_op)
                            OpWrite: begin
                                addr_d    = head_addr;
                                dataw_d   = head_data[7:0];
                                is_read_d = 1'b0;
                                state_d   = StIssue;
                            end
                            OpRead: begin
                                addr_d    = head_addr;
                                is_read_d = 1'b1;
                                state_d   = StIssue;
                            end
                            OpDelay: begin
                                // A zero-length delay is consumed like a no-op.
                                if (head_data != 16'd0) begin
                                    cnt_d   = head_data;
                                    state_d = StDelay;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StIssue: begin
                    if (CLKen) begin
                        if (is_read_q) begin
                            rsp_data_d  = DATAR;
                            rsp_addr_d  = addr_q;
                            rsp_valid_d = 1'b1;
                            state_d     = StResp;
                        end else begin
                            wr_d    = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
                StDelay: begin
                    if (CLKen) begin
                        cnt_d = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = StIdle;
                        end
                    end
                end
                StResp: begin
                    if (RSP_READY) begin
                        rsp_valid_d = 1'b0;
                        state_d     = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            is_read_q   <= 1'b0;
            addr_q      <= '0;
            dataw_q     <= '0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            dataw_q     <= dataw_d;
            wr_q        <= wr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign CMD_READY = cmd_ready;
    assign WR        = wr_q;
    assign ADDR      = addr_q;
    assign DATAW     = dataw_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_ADDR  = rsp_addr_q;
    assign RSP_DATA  = rsp_data_q;
    assign BUSY      = (state_q != StIdle) || !empty;
    assign LEVEL     = count_q;

endmodule

// File: tb/tb_sid_bus_master.sv
// Testbench for sid_bus_master: table-driven single-command vectors, directed
// multi-cycle sequences and randomized batches checked against a command-level
// model of the bus event stream (order, contents and CLKen tick spacing).
module tb_sid_bus_master;

    localparam int Period = 8;  // CLK cycles per CLKen tick

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        CLKen = 1'b0;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD_OP;
    logic [4:0]  CMD_ADDR;
    logic [15:0] CMD_DATA;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b1;
    logic [4:0]  RSP_ADDR;
    logic [7:0]  RSP_DATA;
    logic        WR;
    logic [4:0]  ADDR;
    logic [7:0]  DATAW;
    logic [7:0]  DATAR;
    logic        FLUSH;
    logic        BUSY;
    logic [4:0]  LEVEL;

    sid_bus_master #(.FIFO_DEPTH(16)) dut (
        .CLK(CLK), .RSTn(RSTn), .CLKen(CLKen),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ADDR(RSP_ADDR),
        .RSP_DATA(RSP_DATA), .WR(WR), .ADDR(ADDR), .DATAW(DATAW), .DATAR(DATAR),
        .FLUSH(FLUSH), .BUSY(BUSY), .LEVEL(LEVEL)
    );

    always #5 CLK = ~CLK;

    // SID register file stand-in: combinational read data per address.
    function automatic logic [7:0] datar_of(input logic [4:0] a);
        if (a == 5'h1B) return 8'hA5;
        return {a, 3'b011} ^ 8'h3C;
    endfunction
    assign DATAR = datar_of(ADDR);

    typedef struct { bit rd; logic [4:0] a; logic [7:0] d; int tick; } ev_t;
    typedef struct { bit rd; logic [4:0] a; logic [7:0] d; int gap; bit chk; } exp_t;
    typedef struct {
        logic [1:0] op; logic [4:0] addr; logic [15:0] data;
        int n_ev; logic [7:0] ev_data; logic [4:0] exp_addr; logic [7:0] exp_dataw;
    } vec_t;

    ev_t  obs[$];
    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   tick  = 0;
    int   ph    = 0;
    bit   rr_rand  = 1'b0;
    bit   rr_fixed = 1'b1;
    int   wr_wide = 0;
    int   rsp_unstable = 0;

    // CLKen strobe and RSP_READY driver, updated just after each rising edge.
    always @(posedge CLK) begin
        #1;
        ph = (ph + 1) % Period;
        CLKen = (ph == 0);
        RSP_READY = rr_rand ? 1'($urandom % 2) : rr_fixed;
    end

    always @(posedge CLK) if (CLKen) tick++;

    // Bus monitor: records every WR pulse and every accepted read response.
    ev_t  mon_ev;
    int   rsp_tick = 0;
    logic p_wr = 1'b0, p_rv = 1'b0, p_rr = 1'b0, p_fl = 1'b0;
    logic [4:0] p_ra = '0;
    logic [7:0] p_rd = '0;
    always @(negedge CLK) begin
        if (WR === 1'b1) begin
            if (p_wr) wr_wide++;
            mon_ev.rd = 1'b0; mon_ev.a = ADDR; mon_ev.d = DATAW; mon_ev.tick = tick;
            obs.push_back(mon_ev);
        end
        if (RSP_VALID && !p_rv) rsp_tick = tick;
        if (p_rv && !p_rr && !p_fl && RSTn)
            if (!RSP_VALID || RSP_ADDR !== p_ra || RSP_DATA !== p_rd) rsp_unstable++;
        if (RSP_VALID && RSP_READY) begin
            mon_ev.rd = 1'b1; mon_ev.a = RSP_ADDR; mon_ev.d = RSP_DATA; mon_ev.tick = rsp_tick;
            obs.push_back(mon_ev);
        end
        p_wr = WR; p_rv = RSP_VALID; p_rr = RSP_READY; p_fl = FLUSH;
        p_ra = RSP_ADDR; p_rd = RSP_DATA;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [4:0] a, input logic [15:0] d);
        int n = 0;
        CMD_VALID = 1'b1; CMD_OP = op; CMD_ADDR = a; CMD_DATA = d;
        @(negedge CLK);
        while (!CMD_READY && n < 2000) begin @(negedge CLK); n++; end
        if (n >= 2000) begin
            total++; bad++;
            $display("FAIL push_timeout: got ready=0, want ready=1");
        end
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge CLK);
        while ((BUSY || RSP_VALID) && n < budget) begin @(negedge CLK); n++; end
        check("idle_reached", {30'd0, BUSY, RSP_VALID}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic sync_tick();
        @(posedge CLK);
        while (!CLKen) @(posedge CLK);
        #1;
    endtask

    task automatic run_batch(input bit rnd_rr);
        logic [1:0] op; logic [4:0] a; logic [15:0] d;
        int n, r, noop_run, acc;
        bit first;
        exp_t e;
        obs.delete(); expq.delete();
        rr_rand = rnd_rr;
        push(2'd2, 5'd0, 16'd3);  // lets the queue fill before anything issues
        n = $urandom_range(4, 15);
        noop_run = 0; acc = 1; first = 1'b1;
        for (int i = 0; i < n; i++) begin
            r = $urandom % 10;
            a = 5'($urandom); d = 16'($urandom);
            if (r >= 8 && noop_run == 3) r = 0;
            if (r <= 3) op = 2'd0;
            else if (r <= 6) op = 2'd1;
            else if (r == 7) begin op = 2'd2; d = 16'($urandom_range(1, 3)); end
            else if (r == 8) begin op = 2'd2; d = 16'd0; end
            else op = 2'd3;
            push(op, a, d);
            if (op == 2'd2) begin
                acc += int'(d);
                noop_run = (d == 16'd0) ? noop_run + 1 : 0;
            end else if (op == 2'd3) begin
                noop_run++;
            end else begin
                e.rd = (op == 2'd1); e.a = a;
                e.d = (op == 2'd1) ? datar_of(a) : d[7:0];
                e.gap = acc; e.chk = !first && !rnd_rr;
                expq.push_back(e);
                acc = 1; first = 1'b0; noop_run = 0;
            end
        end
        wait_idle(5000);
        rr_rand = 1'b0;
        check("rand_count", obs.size(), expq.size());
        for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
            check($sformatf("rand_ev%0d_rd", i), obs[i].rd, expq[i].rd);
            check($sformatf("rand_ev%0d_addr", i), obs[i].a, expq[i].a);
            check($sformatf("rand_ev%0d_data", i), obs[i].d, expq[i].d);
            if (expq[i].chk)
                check($sformatf("rand_ev%0d_gap", i), obs[i].tick - obs[i-1].tick, expq[i].gap);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "simulation time limit");
    end

    vec_t vtab[7];
    int   n, t0;

    initial begin
        vtab[0] = '{2'd0, 5'h18, 16'h000F, 1, 8'h0F, 5'h18, 8'h0F};
        vtab[1] = '{2'd1, 5'h1B, 16'h9999, 1, 8'hA5, 5'h1B, 8'h0F};
        vtab[2] = '{2'd3, 5'h05, 16'h00FF, 0, 8'h00, 5'h1B, 8'h0F};
        vtab[3] = '{2'd2, 5'h07, 16'h0002, 0, 8'h00, 5'h1B, 8'h0F};
        vtab[4] = '{2'd0, 5'h00, 16'h1234, 1, 8'h34, 5'h00, 8'h34};
        vtab[5] = '{2'd1, 5'h02, 16'hFFFF, 1, datar_of(5'h02), 5'h02, 8'h34};
        vtab[6] = '{2'd2, 5'h00, 16'h0000, 0, 8'h00, 5'h02, 8'h34};

        RSTn = 1'b0; FLUSH = 1'b0; CMD_VALID = 1'b0;
        CMD_OP = '0; CMD_ADDR = '0; CMD_DATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_wr", WR, 0);
        check("rst_addr", ADDR, 0);
        check("rst_dataw", DATAW, 0);
        check("rst_rsp_valid", RSP_VALID, 0);
        check("rst_rsp_addr", RSP_ADDR, 0);
        check("rst_rsp_data", RSP_DATA, 0);
        check("rst_level", LEVEL, 0);
        check("rst_busy", BUSY, 0);
        RSTn = 1'b1;
        @(negedge CLK);
        check("rst_cmd_ready", CMD_READY, 1);
        @(posedge CLK); #1;

        // Single commands from idle.
        for (int i = 0; i < 7; i++) begin
            obs.delete();
            push(vtab[i].op, vtab[i].addr, vtab[i].data);
            wait_idle(400);
            check($sformatf("vec%0d_events", i), obs.size(), vtab[i].n_ev);
            if (obs.size() > 0) begin
                check($sformatf("vec%0d_rd", i), obs[0].rd, vtab[i].op == 2'd1);
                check($sformatf("vec%0d_ev_addr", i), obs[0].a, vtab[i].addr);
                check($sformatf("vec%0d_ev_data", i), obs[0].d, vtab[i].ev_data);
            end
            check($sformatf("vec%0d_addr", i), ADDR, vtab[i].exp_addr);
            check($sformatf("vec%0d_dataw", i), DATAW, vtab[i].exp_dataw);
            check($sformatf("vec%0d_level", i), LEVEL, 0);
        end

        // Two writes back to back: consecutive ticks.
        obs.delete();
        push(2'd0, 5'h18, 16'h000F);
        push(2'd0, 5'h00, 16'h0034);
        wait_idle(400);
        check("b2b_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("b2b_a0", {obs[0].a, obs[0].d}, {5'h18, 8'h0F});
            check("b2b_a1", {obs[1].a, obs[1].d}, {5'h00, 8'h34});
            check("b2b_gap", obs[1].tick - obs[0].tick, 1);
        end
        check("b2b_level", LEVEL, 0);

        // Delay of 3 plus a zero delay between writes: 4 ticks apart.
        obs.delete();
        push(2'd0, 5'h04, 16'h0011);
        push(2'd2, 5'h00, 16'd3);
        push(2'd2, 5'h00, 16'd0);
        push(2'd0, 5'h04, 16'h0010);
        wait_idle(400);
        check("dly_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("dly_d1", obs[1].d, 8'h10);
            check("dly_gap", obs[1].tick - obs[0].tick, 4);
        end

        // Read response held while RSP_READY is low; the queued write waits.
        rr_fixed = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        obs.delete();
        push(2'd1, 5'h1B, 16'h0000);
        push(2'd0, 5'h05, 16'h00AA);
        n = 0;
        @(negedge CLK);
        while (!RSP_VALID && n < 200) begin @(negedge CLK); n++; end
        check("hold_valid_seen", RSP_VALID, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("hold_valid", RSP_VALID, 1);
            check("hold_addr", RSP_ADDR, 5'h1B);
            check("hold_data", RSP_DATA, 8'hA5);
        end
        check("hold_no_write", obs.size(), 0);
        check("hold_level", LEVEL, 1);
        rr_fixed = 1'b1;
        wait_idle(400);
        check("hold_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check("hold_ev0", {obs[0].rd, obs[0].a, obs[0].d}, {1'b1, 5'h1B, 8'hA5});
            check("hold_ev1", {obs[1].rd, obs[1].a, obs[1].d}, {1'b0, 5'h05, 8'hAA});
        end

        // FIFO full during a long delay; the 17th command waits for a pop.
        obs.delete();
        push(2'd2, 5'h00, 16'd40);
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < 16; i++) push(2'd0, 5'(i), 16'(8'h40 + i));
        @(negedge CLK);
        check("full_level", LEVEL, 16);
        check("full_ready", CMD_READY, 0);
        @(posedge CLK); #1;
        CMD_VALID = 1'b1; CMD_OP = 2'd0; CMD_ADDR = 5'd16; CMD_DATA = 16'h0050;
        n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 1000) begin @(negedge CLK); n++; end
        check("full_ready_rise", CMD_READY, 1);
        check("full_level_at_rise", LEVEL, 15);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        wait_idle(2000);
        check("full_count", obs.size(), 17);
        for (int i = 0; i < 17 && i < obs.size(); i++)
            check($sformatf("full_ev%0d", i), {obs[i].a, obs[i].d}, {5'(i), 8'(8'h40 + i)});

        // FLUSH during a long delay with queued writes.
        obs.delete();
        push(2'd2, 5'h00, 16'd1000);
        for (int i = 0; i < 5; i++) push(2'd0, 5'(8 + i), 16'(8'h60 + i));
        @(negedge CLK);
        check("flush_pre_level", LEVEL, 5);
        @(posedge CLK); #1;
        FLUSH = 1'b1;
        @(negedge CLK);
        check("flush_ready_low", CMD_READY, 0);
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        @(negedge CLK);
        check("flush_level", LEVEL, 0);
        check("flush_busy", BUSY, 0);
        check("flush_addr_kept", ADDR, 5'h10);
        check("flush_dataw_kept", DATAW, 8'h50);
        repeat (30) @(posedge CLK);
        #1;
        check("flush_no_wr", obs.size(), 0);
        sync_tick();
        t0 = tick;
        push(2'd0, 5'h07, 16'h0077);
        wait_idle(400);
        check("flush_after_count", obs.size(), 1);
        if (obs.size() == 1) begin
            check("flush_after_tick", obs[0].tick, t0 + 1);
            check("flush_after_data", obs[0].d, 8'h77);
        end

        // Reset while a write waits in the issue state.
        obs.delete();
        sync_tick();
        push(2'd0, 5'h1F, 16'h00EE);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("issue_level", LEVEL, 0);
        check("issue_busy", BUSY, 1);
        #1;
        RSTn = 1'b0;
        #1;
        check("arst_wr", WR, 0);
        check("arst_addr", ADDR, 0);
        check("arst_dataw", DATAW, 0);
        check("arst_level", LEVEL, 0);
        check("arst_busy", BUSY, 0);
        check("arst_rsp", {RSP_VALID, RSP_ADDR, RSP_DATA}, 0);
        repeat (20) @(posedge CLK);
        #1;
        check("arst_no_wr", obs.size(), 0);
        RSTn = 1'b1;
        push(2'd0, 5'h1F, 16'h00EE);
        wait_idle(400);
        check("arst_after_count", obs.size(), 1);
        if (obs.size() == 1) check("arst_after_ev", {obs[0].a, obs[0].d}, {5'h1F, 8'hEE});

        // Randomized batches; odd batches also randomize RSP_READY.
        for (int b = 0; b < 24; b++) run_batch(b[0]);

        check("wr_one_cycle", wr_wide, 0);
        check("rsp_stable", rsp_unstable, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
